// File: rtl/nn_pkg.sv
// Shared network constants, score types and the accumulator-to-score
// saturation helper used by both the Layer 1 and Layer 2 result paths.
package nn_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned ACC_W       = 32;
    localparam int unsigned SCORE_W     = 20;
    localparam int unsigned IDX_W       = 4;

    typedef logic        [IDX_W-1:0]   idx_t;
    typedef logic signed [ACC_W-1:0]   acc_t;
    typedef logic signed [SCORE_W-1:0] score_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } collect_state_t;

    // Clamp a signed accumulator into the signed score range.
    function automatic score_t sat_score(input acc_t acc);
        acc_t score_max;
        acc_t score_min;
        score_max = {{(ACC_W-SCORE_W+1){1'b0}}, {(SCORE_W-1){1'b1}}};
        score_min = {{(ACC_W-SCORE_W+1){1'b1}}, {(SCORE_W-1){1'b0}}};
        if (acc > score_max)
            return {1'b0, {(SCORE_W-1){1'b1}}};
        else if (acc < score_min)
            return {1'b1, {(SCORE_W-1){1'b0}}};
        else
            return acc[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/score_collector_if.sv
// Stream-in / frame-out bundle between the Layer 2 sequencer, the score
// collector and the argmax stage.
interface score_collector_if;
    import nn_pkg::*;

    logic                           in_valid;
    logic                           in_ready;
    acc_t                           in_data;
    logic                           in_last;
    logic [NUM_CLASSES*SCORE_W-1:0] scores;
    logic                           out_valid;
    logic                           out_ack;
    logic                           frame_err;

    // Driving side: supplies scores and acknowledges frames.
    modport master (
        output in_valid, in_data, in_last, out_ack,
        input  in_ready, scores, out_valid, frame_err
    );

    // Collector side.
    modport slave (
        input  in_valid, in_data, in_last, out_ack,
        output in_ready, scores, out_valid, frame_err
    );

endinterface

// File: rtl/score_collector.sv
// Assembles NUM_CLASSES saturated Layer 2 scores into one frame and holds it
// until the argmax consumer acknowledges. Misframed input is discarded with a
// one-cycle frame_err pulse.
module score_collector
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    score_collector_if.slave  bus
);

    localparam idx_t LAST_IDX = idx_t'(NUM_CLASSES - 1);

    collect_state_t                 state;
    collect_state_t                 state_nx;
    idx_t                           idx;
    logic [NUM_CLASSES*SCORE_W-1:0] slots;
    logic                           err_q;
    logic                           accept;
    logic                           at_last;

    assign accept  = bus.in_valid && (state == FILL);
    assign at_last = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= FILL;
        else
            state <= state_nx;
    end

    // Next state: complete frame enters HOLD, acknowledge releases it.
    always_comb begin
        state_nx = state;
        case (state)
            FILL: if (accept && at_last && bus.in_last) state_nx = HOLD;
            HOLD: if (bus.out_ack)                       state_nx = FILL;
            default:                                     state_nx = FILL;
        endcase
    end

    // Outputs decoded purely from registers.
    always_comb begin
        bus.in_ready  = (state == FILL);
        bus.out_valid = (state == HOLD);
        bus.scores    = slots;
        bus.frame_err = err_q;
    end

    // Slot write, index counter and registered framing-error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            slots <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                    if (idx == idx_t'(i))
                        slots[i*SCORE_W +: SCORE_W] <= sat_score(bus.in_data);
                end
                if (bus.in_last || at_last) begin
                    idx   <= '0;
                    // Error whenever in_last and the final slot disagree.
                    err_q <= (bus.in_last != at_last);
                end else begin
                    idx <= idx + idx_t'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_score_collector.sv
// Scoreboard bench for score_collector: expected saturated scores are queued
// as each score is accepted and compared when the frame is presented.
module tb_score_collector;
    import nn_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    score_collector_if bus();

    score_collector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [SCORE_W-1:0] exp_q[$];
    logic [SCORE_W-1:0] exp_frame [NUM_CLASSES];
    int unsigned        mdl_idx = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [SCORE_W-1:0] ref_sat(input logic [31:0] d);
        longint v;
        v = longint'($signed(d));
        if (v > 524287)       return 20'h7FFFF;
        else if (v < -524288) return 20'h80000;
        else                  return d[19:0];
    endfunction

    function automatic logic [SCORE_W-1:0] slot(input int unsigned i);
        return bus.scores[i*SCORE_W +: SCORE_W];
    endfunction

    task automatic check_frame(input string tag);
        for (int unsigned i = 0; i < NUM_CLASSES; i++)
            check($sformatf("%s_slot%0d", tag, i), 32'(slot(i)), 32'(exp_frame[i]));
    endtask

    // Present one score; waits (bounded) for in_ready, then checks the
    // registered consequences in the cycle after the accepting edge.
    task automatic send(input logic [31:0] d, input logic l);
        int unsigned w;
        logic exp_err;
        logic exp_done;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            check("send_ready_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back(ref_sat(d));
        exp_err  = 1'b0;
        exp_done = 1'b0;
        if (mdl_idx == NUM_CLASSES - 1) begin
            if (l) exp_done = 1'b1;
            else   exp_err  = 1'b1;
        end else if (l) begin
            exp_err = 1'b1;
        end
        if (exp_err || exp_done) mdl_idx = 0;
        else                     mdl_idx++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("frame_err", 32'(bus.frame_err), 32'(exp_err));
        check("out_valid", 32'(bus.out_valid), 32'(exp_done));
        if (exp_done) begin
            for (int unsigned i = 0; i < NUM_CLASSES; i++)
                exp_frame[i] = exp_q.pop_front();
            check_frame("frame");
        end
        if (exp_err) begin
            exp_q.delete();
            @(negedge clk);
            check("err_pulse_width", 32'(bus.frame_err), 32'd0);
            check("err_no_valid", 32'(bus.out_valid), 32'd0);
        end
    endtask

    task automatic idle(input int unsigned n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_frame();
        bus.out_ack = 1'b1;
        @(negedge clk);
        bus.out_ack = 1'b0;
        check("ack_ready", 32'(bus.in_ready), 32'd1);
        check("ack_valid", 32'(bus.out_valid), 32'd0);
    endtask

    logic [31:0] normal_vals [10] = '{32'd5, -32'sd3, 32'd100, 32'd7, 32'd0,
                                      32'd99, -32'sd50, 32'd2, 32'd1, 32'd8};
    logic [31:0] sat_vals [4] = '{32'h0009_0000, 32'hFFF0_0000, 32'h0007_FFFF, 32'hFFF8_0000};

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.out_ack  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_scores", 32'(bus.scores == '0), 32'd1);

        // Normal frame, then hold with ack low for 20 cycles.
        for (int unsigned i = 0; i < 10; i++) send(normal_vals[i], i == 9);
        check("slot2_is_100", 32'(slot(2)), 32'd100);
        for (int unsigned c = 0; c < 20; c++) begin
            @(negedge clk);
            check("hold_ready", 32'(bus.in_ready), 32'd0);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
        end
        check_frame("hold");
        ack_frame();

        // Saturation boundaries.
        for (int unsigned i = 0; i < 10; i++)
            send(i < 4 ? sat_vals[i] : 32'(i), i == 9);
        check("sat0", 32'(slot(0)), 32'h7FFFF);
        check("sat1", 32'(slot(1)), 32'h80000);
        check("sat2", 32'(slot(2)), 32'h7FFFF);
        check("sat3", 32'(slot(3)), 32'h80000);
        ack_frame();

        // Short frame, then a good frame.
        for (int unsigned i = 0; i < 4; i++) send(32'(200 + i), i == 3);
        for (int unsigned i = 0; i < 10; i++) send(32'(300 + i), i == 9);
        check("after_short_slot0", 32'(slot(0)), 32'd300);
        ack_frame();

        // Missing last.
        for (int unsigned i = 0; i < 10; i++) send(32'(400 + i), 1'b0);

        // Random gaps, then in_valid held high during HOLD.
        for (int unsigned i = 0; i < 10; i++) begin
            idle($urandom_range(0, 3));
            send($urandom, i == 9);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_1234;
        bus.in_last  = 1'b0;
        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ready", 32'(bus.in_ready), 32'd0);
        end
        check_frame("bp_hold");
        ack_frame();
        send(32'h0000_1234, 1'b0);
        for (int unsigned i = 1; i < 10; i++) send(32'(500 + i), i == 9);
        check("bp_slot0", 32'(slot(0)), 32'h1234);
        ack_frame();

        // Reset mid-frame.
        for (int unsigned i = 0; i < 6; i++) send(32'(600 + i), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        mdl_idx = 0;
        check("mrst_scores", 32'(bus.scores == '0), 32'd1);
        check("mrst_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_ready", 32'(bus.in_ready), 32'd1);
        for (int unsigned i = 0; i < 10; i++) send(32'(700 + i), i == 9);
        ack_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
